// File: rtl/nanosoc_systable_pkg.sv
// Shared encodings for the system ROM-table walker: FSM states, entry fields,
// AHB-Lite attribute constants and the component ID register layout.
package nanosoc_systable_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CID_A = 3'd1;
  localparam logic [2:0] ST_CID_D = 3'd2;
  localparam logic [2:0] ST_ENT_A = 3'd3;
  localparam logic [2:0] ST_ENT_D = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  localparam int ENT_PRESENT    = 0;
  localparam int ENT_FORMAT     = 1;
  localparam int ENT_OFFSET_MSB = 31;
  localparam int ENT_OFFSET_LSB = 12;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  // Component ID registers sit at the top of the 4 KB table page; only the low byte is checked.
  localparam logic [3:0][11:0] CIDR_OFFSET = {12'hFFC, 12'hFF8, 12'hFF4, 12'hFF0};
  localparam logic [3:0][7:0]  CIDR_EXPECT = {8'hB1, 8'h05, 8'h10, 8'h0D};

  function automatic logic [31:0] entry_offset(input logic [31:0] entry);
    return {entry[ENT_OFFSET_MSB:ENT_OFFSET_LSB], 12'h000};
  endfunction

endpackage

// File: rtl/nanosoc_systable_result_buf.sv
// Result slot register file for the ROM-table walker: one write port driven by
// the walker, one combinational read port selected by slot index.
module nanosoc_systable_result_buf #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic [3:0]        rd_idx,
  output logic [ADDR_W-1:0] rd_data
);

  logic [ADDR_W-1:0] slots [DEPTH];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int k = 0; k < DEPTH; k++) begin
        slots[k] <= '0;
      end
    end else if (wr_en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_idx == 4'(k)) begin
          slots[k] <= wr_data;
        end
      end
    end
  end

  // Indices beyond DEPTH read as zero rather than aliasing onto a real slot.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_idx == 4'(k)) begin
        rd_data = slots[k];
      end
    end
  end

endmodule

// File: rtl/nanosoc_systable_walker.sv
// Walks the system ROM table over AHB-Lite with single word reads and records
// the base address of every present component. Define SYSTABLE_WALKER_CID_CHECK_EN
// to verify the table's component ID registers before reading entries.
module nanosoc_systable_walker
  import nanosoc_systable_pkg::*;
#(
  parameter int                    SYS_ADDR_W    = 32,
  parameter int                    SYS_DATA_W    = 32,
  parameter logic [SYS_ADDR_W-1:0] SYSTABLE_BASE = 32'hF000_0000,
  parameter int                    MAX_ENTRIES   = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  trunc,
  output logic [4:0]            count,
  input  logic [3:0]            rd_idx,
  output logic [SYS_ADDR_W-1:0] rd_base,
  output logic                  rd_valid,
  output logic [SYS_ADDR_W-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic                  HWRITE,
  output logic [SYS_DATA_W-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic [SYS_DATA_W-1:0] HRDATA,
  input  logic                  HRESP
);

  localparam logic [3:0] LAST_IDX = 4'(MAX_ENTRIES - 1);

  logic [2:0]            state;
  logic [3:0]            ent_idx;
  logic [4:0]            count_q;
  logic                  err_q;
  logic                  trunc_q;
  logic [31:0]           entry;
  logic                  entry_end;
  logic                  entry_bad;
  logic                  slot_wr;
  logic [SYS_ADDR_W-1:0] ent_addr;
  logic [SYS_ADDR_W-1:0] slot_addr;
  logic [SYS_ADDR_W-1:0] slot_rd;
`ifdef SYSTABLE_WALKER_CID_CHECK_EN
  logic [1:0]            cid_idx;
  logic                  cid_ok;
`endif

  assign entry     = HRDATA[31:0];
  assign entry_end = (HRDATA == '0);
  assign entry_bad = !entry[ENT_FORMAT];
  assign ent_addr  = SYSTABLE_BASE + SYS_ADDR_W'({ent_idx, 2'b00});
  assign slot_addr = SYSTABLE_BASE + SYS_ADDR_W'(entry_offset(entry));

  // A slot is written on the same data-phase edge that accepts a valid present entry.
  assign slot_wr = (state == ST_ENT_D) && HREADY && !HRESP &&
                   !entry_end && !entry_bad && entry[ENT_PRESENT];

`ifdef SYSTABLE_WALKER_CID_CHECK_EN
  assign cid_ok = (HRDATA[7:0] == CIDR_EXPECT[cid_idx]);
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      ent_idx <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      trunc_q <= 1'b0;
`ifdef SYSTABLE_WALKER_CID_CHECK_EN
      cid_idx <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            count_q <= '0;
            err_q   <= 1'b0;
            trunc_q <= 1'b0;
            ent_idx <= '0;
`ifdef SYSTABLE_WALKER_CID_CHECK_EN
            cid_idx <= '0;
            state   <= ST_CID_A;
`else
            state   <= ST_ENT_A;
`endif
          end
        end
`ifdef SYSTABLE_WALKER_CID_CHECK_EN
        ST_CID_A: begin
          if (HREADY) begin
            state <= ST_CID_D;
          end
        end
        ST_CID_D: begin
          if (HREADY) begin
            if (HRESP || !cid_ok) begin
              err_q <= 1'b1;
              state <= ST_FIN;
            end else if (cid_idx == 2'd3) begin
              state <= ST_ENT_A;
            end else begin
              cid_idx <= cid_idx + 2'd1;
              state   <= ST_CID_A;
            end
          end
        end
`endif
        ST_ENT_A: begin
          if (HREADY) begin
            state <= ST_ENT_D;
          end
        end
        // Error response and bad format both stop the walk; a zero word is a clean end.
        ST_ENT_D: begin
          if (HREADY) begin
            if (HRESP) begin
              err_q <= 1'b1;
              state <= ST_FIN;
            end else if (entry_end) begin
              state <= ST_FIN;
            end else if (entry_bad) begin
              err_q <= 1'b1;
              state <= ST_FIN;
            end else begin
              if (slot_wr) begin
                count_q <= count_q + 5'd1;
              end
              if (ent_idx == LAST_IDX) begin
                trunc_q <= 1'b1;
                state   <= ST_FIN;
              end else begin
                ent_idx <= ent_idx + 4'd1;
                state   <= ST_ENT_A;
              end
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Address phase is driven straight from state so it cannot move during an HREADY stall.
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = '0;
    case (state)
      ST_ENT_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = ent_addr;
      end
`ifdef SYSTABLE_WALKER_CID_CHECK_EN
      ST_CID_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = SYSTABLE_BASE + SYS_ADDR_W'(CIDR_OFFSET[cid_idx]);
      end
`endif
      default: begin
        HTRANS = HTRANS_IDLE;
      end
    endcase
  end

  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign HWRITE    = 1'b0;
  assign HWDATA    = '0;

  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_FIN);
  assign err   = err_q;
  assign trunc = trunc_q;
  assign count = count_q;

  nanosoc_systable_result_buf #(
    .ADDR_W (SYS_ADDR_W),
    .DEPTH  (MAX_ENTRIES)
  ) u_result_buf (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .wr_en   (slot_wr),
    .wr_idx  (count_q[3:0]),
    .wr_data (slot_addr),
    .rd_idx  (rd_idx),
    .rd_data (slot_rd)
  );

  assign rd_valid = ({1'b0, rd_idx} < count_q);
  assign rd_base  = rd_valid ? slot_rd : '0;

endmodule

// File: tb/tb_nanosoc_systable_walker.sv
// Self-checking bench for nanosoc_systable_walker: an AHB-Lite slave model serves
// a randomised ROM table while a behavioural walk model predicts reads and results.
module tb_nanosoc_systable_walker;

  localparam int          MAXE = 4;
  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        HCLK, HRESETn, start;
  logic        busy, done, err, trunc, rd_valid;
  logic [4:0]  count;
  logic [3:0]  rd_idx;
  logic [31:0] rd_base, HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;

  int compared = 0;
  int mismatched = 0;

  // Written by the stimulus process only
  logic [31:0] tbl [16];
  logic [31:0] cidWord [4];
  int          errAt;
  int          waitMode;
  bit          addrStallEn;
  int          walkId = 0;
  logic [31:0] expAddr [32];
  int          expNum;
  int          expCount;
  bit          expErr, expTrunc;
  logic [31:0] expSlot [16];

  // Written by the compare process only
  int readsSeen = 0;
  int doneCount = 0;
  int expPtr = 0;

  nanosoc_systable_walker dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .trunc     (trunc),
    .count     (count),
    .rd_idx    (rd_idx),
    .rd_base   (rd_base),
    .rd_valid  (rd_valid),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endfunction

`ifdef SYSTABLE_WALKER_CID_CHECK_EN
  function automatic logic [7:0] cidByte(int c);
    case (c)
      0:       return 8'h0D;
      1:       return 8'h10;
      2:       return 8'h05;
      default: return 8'hB1;
    endcase
  endfunction
`endif

  function automatic logic [31:0] slaveData(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 32'hFF0 && off <= 32'hFFC) return cidWord[off[3:2]];
    else if (off < 32'd64) return tbl[off[5:2]];
    else return 32'hDEAD_BEEF;
  endfunction

  // Behavioural walk: list of reads the walker must issue and the results it must leave.
  task automatic buildModel();
    int rn;
    bit stop;
    expNum = 0; expCount = 0; expErr = 0; expTrunc = 0; rn = 0; stop = 0;
    for (int k = 0; k < 16; k++) expSlot[k] = 32'h0;
`ifdef SYSTABLE_WALKER_CID_CHECK_EN
    for (int c = 0; c < 4 && !stop; c++) begin
      expAddr[expNum] = BASE + 32'hFF0 + 32'(4 * c);
      expNum++;
      if (rn == errAt) begin expErr = 1; stop = 1; end
      else if (cidWord[c][7:0] != cidByte(c)) begin expErr = 1; stop = 1; end
      rn++;
    end
`endif
    for (int i = 0; i < MAXE && !stop; i++) begin
      expAddr[expNum] = BASE + 32'(4 * i);
      expNum++;
      if (rn == errAt) begin expErr = 1; stop = 1; end
      else if (tbl[i] == 32'h0) stop = 1;
      else if (!tbl[i][1]) begin expErr = 1; stop = 1; end
      else begin
        if (tbl[i][0]) begin
          expSlot[expCount] = BASE + (tbl[i] & 32'hFFFF_F000);
          expCount++;
        end
        if (i == MAXE - 1) expTrunc = 1;
      end
      rn++;
    end
  endtask

  // AHB-Lite slave: one data phase at a time, programmable waits and two-cycle error response.
  initial begin
    bit inData;
    int waitLeft, errStage, rn, lastWalk;
    logic [31:0] data;
    inData = 0; waitLeft = 0; errStage = 0; rn = 0; lastWalk = 0; data = 0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      if (walkId != lastWalk) begin lastWalk = walkId; rn = 0; end
      if (HRESETn !== 1'b1) begin
        inData = 0; HREADY = 1'b1; HRESP = 1'b0;
      end else if (inData) begin
        if (waitLeft > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; waitLeft--;
        end else if (errStage == 1) begin
          HREADY = 1'b0; HRESP = 1'b1; errStage = 2;
        end else begin
          HREADY = 1'b1; HRESP = (errStage == 2);
          HRDATA = (errStage == 2) ? $urandom : data;
          inData = 0;
        end
      end else begin
        HRESP = 1'b0;
        HRDATA = $urandom;
        HREADY = (addrStallEn && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      end
      if (HRESETn === 1'b1 && HREADY === 1'b1 && HTRANS == 2'b10) begin
        inData = 1;
        waitLeft = (waitMode < 0) ? $urandom_range(0, 3) : waitMode;
        data = slaveData(HADDR);
        errStage = (rn == errAt) ? 1 : 0;
        rn++;
      end
    end
  end

  // Compare process: checks bus behaviour against the model on every cycle.
  initial begin
    bit prevAddrStall, prevDataStall, prevDone;
    logic [31:0] prevAddr;
    int seenWalk;
    prevAddrStall = 0; prevDataStall = 0; prevDone = 0; prevAddr = 0; seenWalk = 0;
    forever begin
      @(negedge HCLK);
      #1;
      if (walkId != seenWalk) begin seenWalk = walkId; expPtr = 0; readsSeen = 0; end
      if (HRESETn === 1'b1) begin
        if (prevAddrStall) begin
          checkOutput("stallHtrans", HTRANS, 2'b10);
          checkOutput("stallHaddr", HADDR, prevAddr);
        end
        if (prevDataStall) checkOutput("dataStallHtrans", HTRANS, 2'b00);
      end
      prevAddrStall = (HRESETn === 1'b1 && HTRANS == 2'b10 && HREADY === 1'b0);
      prevDataStall = (HRESETn === 1'b1 && busy === 1'b1 && HTRANS == 2'b00 && HREADY === 1'b0);
      prevAddr = HADDR;
      if (HRESETn === 1'b1 && HTRANS == 2'b10 && HREADY === 1'b1) begin
        if (expPtr < expNum) checkOutput("haddr", HADDR, expAddr[expPtr]);
        else checkOutput("noExtraRead", HTRANS, 2'b00);
        checkOutput("attrs", {HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE}, {3'b010, 3'b000, 4'b0011, 2'b00});
        checkOutput("hwdata", HWDATA, 32'h0);
        checkOutput("busyOnRead", busy, 1'b1);
        expPtr++;
        readsSeen++;
      end
      if (done === 1'b1) begin
        doneCount++;
        checkOutput("doneWidth", prevDone, 1'b0);
        checkOutput("busyInFin", busy, 1'b1);
      end
      prevDone = (done === 1'b1);
    end
  end

  task automatic startPulse();
    @(negedge HCLK); #2;
    start = 1'b1;
    @(negedge HCLK); #2;
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 600) begin
      @(negedge HCLK); #2;
      n++;
    end
    if (busy !== 1'b0) checkOutput("walkTimeout", busy, 1'b0);
  endtask

  task automatic applyStimulus();
    int doneBefore;
    buildModel();
    walkId++;
    doneBefore = doneCount;
    startPulse();
    waitIdle();
    checkOutput("count", count, expCount);
    checkOutput("err", err, expErr);
    checkOutput("trunc", trunc, expTrunc);
    checkOutput("readsIssued", readsSeen, expNum);
    checkOutput("donePulses", doneCount - doneBefore, 1);
    for (int k = 0; k < 16; k++) begin
      rd_idx = 4'(k);
      #1;
      checkOutput("rdValid", rd_valid, (k < expCount));
      checkOutput("rdBase", rd_base, (k < expCount) ? expSlot[k] : 32'h0);
    end
    rd_idx = 4'd0;
  endtask

  task automatic loadTable041();
    for (int k = 0; k < 16; k++) tbl[k] = 32'h0;
    tbl[0] = 32'hF00F_F003;
    tbl[1] = 32'h0020_0002;
    tbl[2] = 32'h0000_0000;
  endtask

  initial begin
    int n, doneBefore;
    HRESETn = 1'b0; start = 1'b0; rd_idx = 4'd0;
    errAt = -1; waitMode = 0; addrStallEn = 0;
    for (int k = 0; k < 16; k++) tbl[k] = 32'h0;
    cidWord[0] = 32'h0000_000D; cidWord[1] = 32'h0000_0010;
    cidWord[2] = 32'h0000_0005; cidWord[3] = 32'h0000_00B1;

    repeat (3) @(negedge HCLK);
    #2;
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetDone", done, 1'b0);
    checkOutput("resetErr", err, 1'b0);
    checkOutput("resetTrunc", trunc, 1'b0);
    checkOutput("resetCount", count, 5'd0);
    checkOutput("resetHtrans", HTRANS, 2'b00);
    checkOutput("resetHaddr", HADDR, 32'h0);
    checkOutput("resetRdValid", rd_valid, 1'b0);
    checkOutput("resetRdBase", rd_base, 32'h0);
    HRESETn = 1'b1;

    $display("[TB] basic table, zero wait");
    loadTable041();
    applyStimulus();
    checkOutput("model041Slot0", expSlot[0], 32'hE00F_F000);
    checkOutput("t041Count", count, 5'd1);
    checkOutput("t041Err", err, 1'b0);
    checkOutput("t041Trunc", trunc, 1'b0);
    rd_idx = 4'd0; #1;
    checkOutput("t041Slot0", rd_base, 32'hE00F_F000);

    $display("[TB] basic table, three wait states");
    waitMode = 3;
    applyStimulus();
    checkOutput("t042Count", count, 5'd1);
    rd_idx = 4'd0; #1;
    checkOutput("t042Slot0", rd_base, 32'hE00F_F000);

    $display("[TB] error response on entry 1");
    waitMode = 1;
`ifdef SYSTABLE_WALKER_CID_CHECK_EN
    errAt = 5;
`else
    errAt = 1;
`endif
    applyStimulus();
    checkOutput("t043Err", err, 1'b1);
    checkOutput("t043Count", count, 5'd1);
    errAt = -1;

    $display("[TB] full table, truncated");
    waitMode = 0;
    for (int k = 0; k < 16; k++) tbl[k] = 32'h0000_1003;
    applyStimulus();
    checkOutput("t044Count", count, 5'd4);
    checkOutput("t044Trunc", trunc, 1'b1);
    rd_idx = 4'd3; #1;
    checkOutput("t044Slot3", rd_base, 32'hF000_1000);

`ifdef SYSTABLE_WALKER_CID_CHECK_EN
    $display("[TB] bad component ID");
    cidWord[1] = 32'h0000_0090;
    applyStimulus();
    checkOutput("t045Err", err, 1'b1);
    checkOutput("t045Count", count, 5'd0);
    checkOutput("t045Reads", readsSeen, 2);
    cidWord[1] = 32'h0000_0010;
`endif

    $display("[TB] randomised walks");
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 9))
          0:       tbl[k] = 32'h0;
          1:       tbl[k] = ($urandom & 32'hFFFF_FFFD) | 32'h0000_0004;
          2, 3:    tbl[k] = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0002;
          default: tbl[k] = $urandom | 32'h0000_0003;
        endcase
      end
      errAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
      waitMode = ($urandom_range(0, 4) == 4) ? -1 : $urandom_range(0, 3);
      addrStallEn = ($urandom_range(0, 1) == 1);
`ifdef SYSTABLE_WALKER_CID_CHECK_EN
      for (int c = 0; c < 4; c++) cidWord[c] = ($urandom & 32'hFFFF_FF00) | {24'h0, cidByte(c)};
      if ($urandom_range(0, 5) == 0) cidWord[$urandom_range(0, 3)] ^= 32'h0000_0040;
`endif
      applyStimulus();
    end

    $display("[TB] start while busy, then reset mid-walk");
    errAt = -1; waitMode = 2; addrStallEn = 0;
    for (int k = 0; k < 16; k++) tbl[k] = 32'h0000_1003;
    buildModel();
    walkId++;
    doneBefore = doneCount;
    startPulse();
    n = 0;
    while (readsSeen < 2 && n < 200) begin @(negedge HCLK); #2; n++; end
    checkOutput("t046ReachedRead2", (readsSeen >= 2), 1'b1);
    startPulse();
    checkOutput("t046BusyAfterStart", busy, 1'b1);
    n = 0;
    while (readsSeen < 3 && n < 200) begin @(negedge HCLK); #2; n++; end
    checkOutput("t046ReachedRead3", (readsSeen >= 3), 1'b1);
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    #2;
    checkOutput("t046RstBusy", busy, 1'b0);
    checkOutput("t046RstCount", count, 5'd0);
    checkOutput("t046RstHtrans", HTRANS, 2'b00);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    #2;
    checkOutput("t046Busy", busy, 1'b0);
    checkOutput("t046Count", count, 5'd0);
    checkOutput("t046Htrans", HTRANS, 2'b00);
    checkOutput("t046NoDone", doneCount - doneBefore, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
